// File: rtl/mc_control_unit_pkg.sv
// -----------------------------------------------------------------------------
// mc_control_unit_pkg
// Shared definitions for the multicycle control unit.
//   - state_t     : FSM state encoding (4-bit, 10 states)
//   - OP_*/CMD_*  : instruction field values (op = instr[27:26], cmd = instr[24:21])
//   - ALU_*       : ALU control codes (EOR/MOV need a 3-bit alu_control)
//   - SRC_*/RES_* : datapath mux select constants
//   - is_test_cmd : CMP/CMN/TST, the compare/test commands that never write Rd
// No ports (package).
// -----------------------------------------------------------------------------
package mc_control_unit_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXECR  = 4'd2,
        S_EXECI  = 4'd3,
        S_ALUWB  = 4'd4,
        S_MEMADR = 4'd5,
        S_MEMRD  = 4'd6,
        S_MEMWB  = 4'd7,
        S_MEMWR  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_BR  = 2'd2;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;
    localparam logic [2:0] ALU_MOV = 3'd5;

    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_RESULT  = 1'b1;
    localparam logic [1:0] SRC_A_REG   = 2'd0;
    localparam logic [1:0] SRC_A_PC    = 2'd1;
    localparam logic [1:0] SRC_B_REG   = 2'd0;
    localparam logic [1:0] SRC_B_IMM   = 2'd1;
    localparam logic [1:0] SRC_B_FOUR  = 2'd2;
    localparam logic [1:0] RES_ALUOUT  = 2'd0;
    localparam logic [1:0] RES_MEMDATA = 2'd1;
    localparam logic [1:0] RES_ALU     = 2'd2;

    function automatic logic is_test_cmd(input logic [3:0] cmd);
        return (cmd == CMD_TST) || (cmd == CMD_CMP) || (cmd == CMD_CMN);
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// -----------------------------------------------------------------------------
// mc_control_unit_if
// Bundle between the instruction register / datapath and the control unit.
//   Inputs to the control unit : i_op, i_funct, i_rd, i_mem_ready
//   Outputs of the control unit: enables (ir_write, pc_update, branch, pcs,
//     reg_w, mem_w, flag_w, illegal), mux selects (adr_src, alu_src_a/b,
//     result_src, imm_src, reg_src), alu_control, no_write.
// Modports: slave = control unit, master = datapath side.
// -----------------------------------------------------------------------------
interface mc_control_unit_if #(parameter int ALU_CTRL_W = 2);

    logic [1:0]            i_op;
    logic [5:0]            i_funct;
    logic [3:0]            i_rd;
    logic                  i_mem_ready;

    logic                  o_ir_write;
    logic                  o_pc_update;
    logic                  o_branch;
    logic                  o_pcs;
    logic                  o_reg_w;
    logic                  o_mem_w;
    logic                  o_adr_src;
    logic [1:0]            o_alu_src_a;
    logic [1:0]            o_alu_src_b;
    logic [1:0]            o_result_src;
    logic [1:0]            o_imm_src;
    logic [1:0]            o_reg_src;
    logic [ALU_CTRL_W-1:0] o_alu_control;
    logic [1:0]            o_flag_w;
    logic                  o_no_write;
    logic                  o_illegal;

    modport slave (
        input  i_op, i_funct, i_rd, i_mem_ready,
        output o_ir_write, o_pc_update, o_branch, o_pcs, o_reg_w, o_mem_w,
               o_adr_src, o_alu_src_a, o_alu_src_b, o_result_src, o_imm_src,
               o_reg_src, o_alu_control, o_flag_w, o_no_write, o_illegal
    );

    modport master (
        output i_op, i_funct, i_rd, i_mem_ready,
        input  o_ir_write, o_pc_update, o_branch, o_pcs, o_reg_w, o_mem_w,
               o_adr_src, o_alu_src_a, o_alu_src_b, o_result_src, o_imm_src,
               o_reg_src, o_alu_control, o_flag_w, o_no_write, o_illegal
    );

endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// -----------------------------------------------------------------------------
// mc_control_unit_alu_decoder
// Combinational ALU decode for data-processing instructions.
//   i_cmd         : funct[4:1]
//   i_s           : funct[0] (set-flags)
//   i_alu_op      : 0 -> plain ADD (address / PC arithmetic), 1 -> decode cmd
//   o_alu_control : ALU op code, zero when unsupported
//   o_flag_w      : [1]=NZ, [0]=CV write enables (unqualified by state)
//   o_no_write    : compare/test command, Rd must not be written
//   o_unsupported : cmd outside the decode table for this ALU_CTRL_W, or test without S
// -----------------------------------------------------------------------------
module mc_control_unit_alu_decoder
    import mc_control_unit_pkg::*;
#(
    parameter int ALU_CTRL_W = 2
) (
    input  logic [3:0]            i_cmd,
    input  logic                  i_s,
    input  logic                  i_alu_op,
    output logic [ALU_CTRL_W-1:0] o_alu_control,
    output logic [1:0]            o_flag_w,
    output logic                  o_no_write,
    output logic                  o_unsupported
);

    // EOR/MOV codes only fit in a 3-bit control word.
    localparam logic HAS_EXT = (ALU_CTRL_W >= 3);

    logic [2:0] w_code;
    logic       w_known;
    logic       w_arith;   // commands whose C/V flags are meaningful
    logic       w_test;
    logic       w_unsup;

    always_comb begin
        w_code  = ALU_ADD;
        w_known = 1'b1;
        w_arith = 1'b0;
        case (i_cmd)
            CMD_ADD: begin w_code = ALU_ADD; w_arith = 1'b1; end
            CMD_SUB: begin w_code = ALU_SUB; w_arith = 1'b1; end
            CMD_AND: w_code = ALU_AND;
            CMD_ORR: w_code = ALU_ORR;
            CMD_CMP: begin w_code = ALU_SUB; w_arith = 1'b1; end
            CMD_CMN: begin w_code = ALU_ADD; w_arith = 1'b1; end
            CMD_TST: w_code = ALU_AND;
            CMD_EOR: begin w_code = ALU_EOR; w_known = HAS_EXT; end
            CMD_MOV: begin w_code = ALU_MOV; w_known = HAS_EXT; end
            default: w_known = 1'b0;
        endcase
    end

    assign w_test  = is_test_cmd(i_cmd);
    // A compare/test without S would do nothing at all, so treat it as illegal.
    assign w_unsup = i_alu_op & (~w_known | (w_test & ~i_s));

    assign o_unsupported = w_unsup;
    assign o_no_write    = i_alu_op & w_test;
    assign o_flag_w[1]   = i_alu_op & i_s & ~w_unsup;
    assign o_flag_w[0]   = o_flag_w[1] & w_arith;
    assign o_alu_control = (i_alu_op & ~w_unsup) ? ALU_CTRL_W'(w_code) : '0;

endmodule

// File: rtl/mc_control_unit.sv
// -----------------------------------------------------------------------------
// mc_control_unit
// Multicycle control unit: Moore FSM sequencing FETCH/DECODE/EXECUTE/MEM/
// WRITEBACK over a shared memory and ALU, plus combinational ALU decode.
//   clk     : rising-edge clock
//   reset   : asynchronous, active-high; forces FETCH and silences all enables
//   ctrl_if : slave side of mc_control_unit_if (instruction fields, mem_ready
//             in; enables, mux selects, alu_control, illegal out)
// Parameters:
//   ALU_CTRL_W : 2 = ADD/SUB/AND/ORR, 3 = also EOR/MOV
//   MEM_STALL  : 1 = FETCH/MEMRD/MEMWR wait for mem_ready, 0 = ignore it
// -----------------------------------------------------------------------------
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int ALU_CTRL_W = 2,
    parameter bit MEM_STALL  = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    mc_control_unit_if.slave   ctrl_if
);

    state_t r_state;
    state_t w_next;

    logic       w_mem_rdy;
    logic       w_op_i;
    logic       w_op_l;
    logic       w_alu_op;
    logic       w_exec;
    logic       w_ir_write;
    logic       w_pc_update;
    logic       w_reg_w;
    logic       w_mem_w;
    logic       w_branch;
    logic       w_illegal;
    logic       w_adr_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [1:0] w_result_src;

    logic [ALU_CTRL_W-1:0] w_alu_control;
    logic [1:0]            w_dec_flag_w;
    logic                  w_no_write;
    logic                  w_unsup;
    logic                  w_run;

    assign w_mem_rdy = MEM_STALL ? ctrl_if.i_mem_ready : 1'b1;
    assign w_op_i    = ctrl_if.i_funct[5];
    assign w_op_l    = ctrl_if.i_funct[0];

    mc_control_unit_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .i_cmd         (ctrl_if.i_funct[4:1]),
        .i_s           (ctrl_if.i_funct[0]),
        .i_alu_op      (w_alu_op),
        .o_alu_control (w_alu_control),
        .o_flag_w      (w_dec_flag_w),
        .o_no_write    (w_no_write),
        .o_unsupported (w_unsup)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_alu_op     = 1'b0;
        w_exec       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_update  = 1'b0;
        w_reg_w      = 1'b0;
        w_mem_w      = 1'b0;
        w_branch     = 1'b0;
        w_illegal    = 1'b0;
        w_adr_src    = ADR_PC;
        w_src_a      = SRC_A_REG;
        w_src_b      = SRC_B_REG;
        w_result_src = RES_ALUOUT;
        case (r_state)
            S_FETCH: begin
                // PC+4 computed through the ALU and written back directly.
                w_src_a      = SRC_A_PC;
                w_src_b      = SRC_B_FOUR;
                w_result_src = RES_ALU;
                w_ir_write   = w_mem_rdy;
                w_pc_update  = w_mem_rdy;
                if (w_mem_rdy) w_next = S_DECODE;
            end
            S_DECODE: begin
                // PC+8 on the ALU so R15 reads see the architectural value.
                w_src_a      = SRC_A_PC;
                w_src_b      = SRC_B_FOUR;
                w_result_src = RES_ALU;
                case (ctrl_if.i_op)
                    OP_DP:   w_next = w_op_i ? S_EXECI : S_EXECR;
                    OP_MEM:  w_next = S_MEMADR;
                    OP_BR:   w_next = S_BRANCH;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_EXECR: begin
                w_alu_op  = 1'b1;
                w_exec    = 1'b1;
                w_illegal = w_unsup;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_alu_op  = 1'b1;
                w_exec    = 1'b1;
                w_src_b   = SRC_B_IMM;
                w_illegal = w_unsup;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                // Decode kept live so the write can be suppressed here.
                w_alu_op = 1'b1;
                w_reg_w  = ~w_no_write & ~w_unsup;
                w_next   = S_FETCH;
            end
            S_MEMADR: begin
                w_src_b = SRC_B_IMM;
                w_next  = w_op_l ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_adr_src = ADR_RESULT;
                if (w_mem_rdy) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_MEMDATA;
                w_reg_w      = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                // Write request stays up through the completing cycle.
                w_adr_src = ADR_RESULT;
                w_mem_w   = 1'b1;
                if (w_mem_rdy) w_next = S_FETCH;
            end
            S_BRANCH: begin
                w_src_b      = SRC_B_IMM;
                w_result_src = RES_ALU;
                w_branch     = 1'b1;
                w_next       = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Reset is async, so the state alone cannot silence FETCH's ir_write
    // (it follows mem_ready); every enable is gated directly.
    assign w_run = ~reset;

    assign ctrl_if.o_ir_write    = w_ir_write  & w_run;
    assign ctrl_if.o_pc_update   = w_pc_update & w_run;
    assign ctrl_if.o_reg_w       = w_reg_w     & w_run;
    assign ctrl_if.o_mem_w       = w_mem_w     & w_run;
    assign ctrl_if.o_branch      = w_branch    & w_run;
    assign ctrl_if.o_illegal     = w_illegal   & w_run;
    assign ctrl_if.o_flag_w      = (w_exec & w_run) ? w_dec_flag_w : 2'b00;
    assign ctrl_if.o_pcs         = (((ctrl_if.i_rd == 4'd15) & w_reg_w) | w_branch) & w_run;
    assign ctrl_if.o_no_write    = w_no_write;
    assign ctrl_if.o_alu_control = w_alu_control;
    assign ctrl_if.o_adr_src     = w_adr_src;
    assign ctrl_if.o_alu_src_a   = w_src_a;
    assign ctrl_if.o_alu_src_b   = w_src_b;
    assign ctrl_if.o_result_src  = w_result_src;
    assign ctrl_if.o_imm_src     = ctrl_if.i_op;
    assign ctrl_if.o_reg_src     = {(ctrl_if.i_op == OP_MEM) & ~w_op_l, ctrl_if.i_op == OP_BR};

endmodule

// File: tb/tb_mc_control_unit.sv
module tb_mc_control_unit;

    logic clk;
    logic reset;
    logic [1:0] t_op;
    logic [5:0] t_funct;
    logic [3:0] t_rd;
    logic       t_mrdy;

    int checks = 0;
    int errors = 0;
    int n_instr = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mc_control_unit_if #(.ALU_CTRL_W(2)) if2 ();
    mc_control_unit_if #(.ALU_CTRL_W(3)) if3 ();

    assign if2.i_op = t_op;   assign if2.i_funct = t_funct;
    assign if2.i_rd = t_rd;   assign if2.i_mem_ready = t_mrdy;
    assign if3.i_op = t_op;   assign if3.i_funct = t_funct;
    assign if3.i_rd = t_rd;   assign if3.i_mem_ready = t_mrdy;

    mc_control_unit #(.ALU_CTRL_W(2), .MEM_STALL(1'b1)) u_dut2 (.clk(clk), .reset(reset), .ctrl_if(if2));
    mc_control_unit #(.ALU_CTRL_W(3), .MEM_STALL(1'b1)) u_dut3 (.clk(clk), .reset(reset), .ctrl_if(if3));

    typedef struct packed {
        logic       ir_write;
        logic       pc_update;
        logic       reg_w;
        logic       mem_w;
        logic       branch;
        logic       illegal;
        logic       pcs;
        logic       adr_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] result_src;
        logic [1:0] flag_w;
        logic       no_write;
        logic [2:0] alu_ctrl;
    } obs_t;

    // Instruction phases as listed in the behaviour description.
    typedef enum {P_FETCH, P_DECODE, P_EXECR, P_EXECI, P_ALUWB,
                  P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_BRANCH} ph_t;

    // Reference ALU table: code, implemented, needs 3-bit control, test-class, C/V class.
    logic [2:0] code_tab [16];
    bit valid_tab [16];
    bit w3_tab    [16];
    bit test_tab  [16];
    bit arith_tab [16];

    function automatic obs_t sample(input int w);
        obs_t o;
        o = '0;
        if (w == 2) begin
            o.ir_write = if2.o_ir_write;   o.pc_update = if2.o_pc_update;
            o.reg_w    = if2.o_reg_w;      o.mem_w     = if2.o_mem_w;
            o.branch   = if2.o_branch;     o.illegal   = if2.o_illegal;
            o.pcs      = if2.o_pcs;        o.adr_src   = if2.o_adr_src;
            o.src_a    = if2.o_alu_src_a;  o.src_b     = if2.o_alu_src_b;
            o.result_src = if2.o_result_src; o.flag_w  = if2.o_flag_w;
            o.no_write = if2.o_no_write;   o.alu_ctrl  = {1'b0, if2.o_alu_control};
        end else begin
            o.ir_write = if3.o_ir_write;   o.pc_update = if3.o_pc_update;
            o.reg_w    = if3.o_reg_w;      o.mem_w     = if3.o_mem_w;
            o.branch   = if3.o_branch;     o.illegal   = if3.o_illegal;
            o.pcs      = if3.o_pcs;        o.adr_src   = if3.o_adr_src;
            o.src_a    = if3.o_alu_src_a;  o.src_b     = if3.o_alu_src_b;
            o.result_src = if3.o_result_src; o.flag_w  = if3.o_flag_w;
            o.no_write = if3.o_no_write;   o.alu_ctrl  = if3.o_alu_control;
        end
        return o;
    endfunction

    // Expected outputs for one cycle of a phase; m marks the fields the
    // behaviour actually defines in that phase (others are free).
    function automatic void expect_cyc(input ph_t ph, input int w, input logic mrdy,
                                       output obs_t e, output obs_t m);
        logic [3:0] cmd;
        bit s, sup;
        cmd = t_funct[4:1];
        s   = t_funct[0];
        sup = valid_tab[cmd] && (!w3_tab[cmd] || w >= 3) && (!test_tab[cmd] || s);
        e = '0;
        m = '1;
        m.adr_src = 1'b0; m.src_a = 2'b00; m.src_b = 2'b00; m.result_src = 2'b00;
        case (ph)
            P_FETCH: begin
                e.ir_write = mrdy; e.pc_update = mrdy;
                m.adr_src = 1'b1; m.src_a = 2'b11; m.src_b = 2'b11; m.result_src = 2'b11;
                e.src_a = 2'd1; e.src_b = 2'd2; e.result_src = 2'd2;
            end
            P_DECODE: begin
                m.src_a = 2'b11; m.src_b = 2'b11; m.result_src = 2'b11;
                e.src_a = 2'd1; e.src_b = 2'd2; e.result_src = 2'd2;
                e.illegal = (t_op == 2'd3);
            end
            P_EXECR, P_EXECI: begin
                m.src_a = 2'b11; m.src_b = 2'b11;
                e.src_b     = (ph == P_EXECI) ? 2'd1 : 2'd0;
                e.alu_ctrl  = sup ? code_tab[cmd] : 3'd0;
                e.flag_w[1] = s && sup;
                e.flag_w[0] = s && sup && arith_tab[cmd];
                e.no_write  = test_tab[cmd];
                e.illegal   = !sup;
            end
            P_ALUWB: begin
                m.result_src = 2'b11; m.alu_ctrl = 3'b000; m.no_write = 1'b0;
                e.reg_w = !test_tab[cmd] && sup;
                e.pcs   = e.reg_w && (t_rd == 4'd15);
            end
            P_MEMADR: begin
                m.src_a = 2'b11; m.src_b = 2'b11;
                e.src_b = 2'd1;
            end
            P_MEMRD: begin
                m.adr_src = 1'b1; e.adr_src = 1'b1;
            end
            P_MEMWB: begin
                m.result_src = 2'b11; e.result_src = 2'd1;
                e.reg_w = 1'b1; e.pcs = (t_rd == 4'd15);
            end
            P_MEMWR: begin
                m.adr_src = 1'b1; e.adr_src = 1'b1; e.mem_w = 1'b1;
            end
            default: begin // P_BRANCH
                m.src_a = 2'b11; m.src_b = 2'b11; m.result_src = 2'b11;
                e.src_b = 2'd1; e.result_src = 2'd2; e.branch = 1'b1; e.pcs = 1'b1;
            end
        endcase
    endfunction

    task automatic cmp(input string tag, input obs_t got, input obs_t exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; checks mid-cycle, returns after next edge.
    task automatic cycle(input ph_t ph, input logic mrdy, input string tag);
        obs_t e, m;
        t_mrdy = mrdy;
        #3;
        for (int w = 2; w <= 3; w++) begin
            expect_cyc(ph, w, mrdy, e, m);
            cmp($sformatf("%s w%0d", tag, w), sample(w) & m, e & m);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        obs_t en;
        en = '0;
        en.ir_write = 1'b1; en.pc_update = 1'b1; en.reg_w = 1'b1; en.mem_w = 1'b1;
        en.branch = 1'b1; en.illegal = 1'b1; en.pcs = 1'b1; en.flag_w = 2'b11;
        for (int w = 2; w <= 3; w++) cmp($sformatf("%s w%0d", tag, w), sample(w) & en, '0);
    endtask

    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                             input int fst, input int mst, input bit abort);
        ph_t q[$];
        string tag;
        n_instr++;
        t_op = op; t_funct = funct; t_rd = rd;
        q.push_back(P_FETCH);
        q.push_back(P_DECODE);
        case (op)
            2'd0: begin q.push_back(funct[5] ? P_EXECI : P_EXECR); q.push_back(P_ALUWB); end
            2'd1: begin
                q.push_back(P_MEMADR);
                if (funct[0]) begin q.push_back(P_MEMRD); q.push_back(P_MEMWB); end
                else q.push_back(P_MEMWR);
            end
            2'd2: q.push_back(P_BRANCH);
            default: ;
        endcase
        foreach (q[k]) begin
            tag = $sformatf("i%0d %s", n_instr, q[k].name());
            if (q[k] == P_FETCH || q[k] == P_MEMRD || q[k] == P_MEMWR) begin
                int n;
                n = (q[k] == P_FETCH) ? fst : mst;
                for (int j = 0; j < n; j++) cycle(q[k], 1'b0, tag);
                if (abort && q[k] == P_MEMWR) begin
                    // Reset lands mid-cycle while the write is still stalled.
                    t_mrdy = 1'b0;
                    #2;
                    reset = 1'b1;
                    #1;
                    check_quiet({tag, " rst-async"});
                    @(posedge clk);
                    #1;
                    t_mrdy = 1'b1;
                    #2;
                    check_quiet({tag, " rst-held"});
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                    return;
                end
                cycle(q[k], 1'b1, tag);
            end else begin
                cycle(q[k], 1'($urandom_range(0, 1)), tag);
            end
        end
    endtask

    initial begin
        logic [3:0] cmds [9];
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1011, 4'b1000, 4'b0001, 4'b1101};
        for (int i = 0; i < 16; i++) begin
            code_tab[i] = 3'd0; valid_tab[i] = 0; w3_tab[i] = 0; test_tab[i] = 0; arith_tab[i] = 0;
        end
        code_tab[4]  = 3'd0; valid_tab[4]  = 1; arith_tab[4]  = 1;              // ADD
        code_tab[2]  = 3'd1; valid_tab[2]  = 1; arith_tab[2]  = 1;              // SUB
        code_tab[0]  = 3'd2; valid_tab[0]  = 1;                                 // AND
        code_tab[12] = 3'd3; valid_tab[12] = 1;                                 // ORR
        code_tab[10] = 3'd1; valid_tab[10] = 1; arith_tab[10] = 1; test_tab[10] = 1; // CMP
        code_tab[11] = 3'd0; valid_tab[11] = 1; arith_tab[11] = 1; test_tab[11] = 1; // CMN
        code_tab[8]  = 3'd2; valid_tab[8]  = 1; test_tab[8]  = 1;               // TST
        code_tab[1]  = 3'd4; valid_tab[1]  = 1; w3_tab[1]  = 1;                 // EOR
        code_tab[13] = 3'd5; valid_tab[13] = 1; w3_tab[13] = 1;                 // MOV

        reset = 1'b1; t_mrdy = 1'b1; t_op = 2'd0; t_funct = 6'd0; t_rd = 4'd0;
        #3;
        check_quiet("reset");
        @(posedge clk);
        #1;
        check_quiet("reset-edge");
        reset = 1'b0;

        run_instr(2'd0, 6'b001000, 4'd1,  0, 0, 0);   // ADD r1
        run_instr(2'd0, 6'b010101, 4'd0,  0, 0, 0);   // CMP (S=1)
        run_instr(2'd0, 6'b000100, 4'd2,  1, 0, 0);   // SUB without S, fetch stall
        run_instr(2'd1, 6'b011001, 4'd3,  0, 3, 0);   // LDR, 3 stalls in MEMRD
        run_instr(2'd1, 6'b011000, 4'd4,  0, 2, 1);   // STR, reset during MEMWR stall
        run_instr(2'd2, 6'b100000, 4'd15, 0, 0, 0);   // B
        run_instr(2'd3, 6'b000000, 4'd0,  0, 0, 0);   // illegal op
        run_instr(2'd0, 6'b100010, 4'd3,  0, 0, 0);   // EOR imm
        run_instr(2'd0, 6'b111011, 4'd15, 0, 0, 0);   // MOVS to r15
        run_instr(2'd0, 6'b001001, 4'd15, 0, 0, 0);   // ADDS to r15
        run_instr(2'd0, 6'b010100, 4'd5,  0, 0, 0);   // CMP without S
        run_instr(2'd1, 6'b111000, 4'd6,  2, 1, 0);   // STR with stalls

        for (int r = 0; r < 40; r++) begin
            logic [1:0] op;
            logic [5:0] f;
            logic [3:0] rd;
            int sel;
            sel = int'($urandom_range(0, 9));
            op  = (sel < 4) ? 2'd0 : (sel < 7) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
            f   = 6'($urandom);
            if (op == 2'd0 && $urandom_range(0, 1) == 1) f[4:1] = cmds[$urandom_range(0, 8)];
            rd  = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
            run_instr(op, f, rd, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
        end
        cycle(P_FETCH, 1'b1, "final FETCH");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
